stage1_if: RTL and testbench

//   Instruction fetch (IF) stage of the five-stage MIPS CPU; feeds stage2_id (inst, pc4).

---
 rtl/stage1_if_if.sv | 10 +
 rtl/stage1_if.sv | 142 ++++++++++++++
 tb/tb_stage1_if.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/stage1_if_if.sv
// Instruction-memory request/ack bus between the fetch stage (master) and memory (slave).
interface stage1_if_if;
  logic        req;
  logic [31:0] addr;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, addr, input  ack, rdata);
  modport slave  (input  req, addr, output ack, rdata);
endinterface

// File: rtl/stage1_if.sv
// MIPS IF stage: one-outstanding imem fetch, small fetch buffer, registered inst/pc4 to ID.
module stage1_if #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [31:0]        branch_target,
  stage1_if_if.master        imem,
  output logic [31:0]        inst,
  output logic [31:0]        pc4_out,
  output logic               valid_out
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [31:0] word;
    logic [31:0] pc4;
  } fetch_ent_t;

  typedef enum logic [1:0] {IDLE, FETCH, FULL, DRAIN} state_t;

  state_t         state, state_nxt;
  logic [31:0]    fetch_pc, fetch_pc_nxt;
  logic [31:0]    pend_pc, pend_pc_nxt;
  logic [31:0]    tgt;
  fetch_ent_t     fifo [FIFO_DEPTH];
  fetch_ent_t     head;
  logic [PW-1:0]  wr_ptr, rd_ptr;
  logic [CW-1:0]  count, count_nxt;
  logic           push, pop;
  logic           unused_tgt_lsb;

  assign tgt            = {branch_target[31:2], 2'b00};
  assign unused_tgt_lsb = ^branch_target[1:0];

  assign imem.req  = (state == FETCH) || (state == DRAIN);
  assign imem.addr = fetch_pc;

  assign push      = (state == FETCH) && imem.ack && !branch_taken;
  assign pop       = !stall && !branch_taken && (count != '0);
  assign count_nxt = count + CW'(push) - CW'(pop);
  assign head      = fifo[rd_ptr];

  // A request is only left open while count_nxt leaves a free slot for its ack.
  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    pend_pc_nxt  = pend_pc;
    case (state)
      IDLE: begin
        state_nxt = FETCH;
        if (branch_taken) fetch_pc_nxt = tgt;
      end
      FETCH: begin
        if (branch_taken) begin
          if (imem.ack) begin
            fetch_pc_nxt = tgt;
          end else begin
            pend_pc_nxt = tgt;
            state_nxt   = DRAIN;
          end
        end else if (imem.ack) begin
          fetch_pc_nxt = fetch_pc + 32'd4;
          state_nxt    = (count_nxt < CW'(FIFO_DEPTH)) ? FETCH : FULL;
        end
      end
      FULL: begin
        if (branch_taken) begin
          fetch_pc_nxt = tgt;
          state_nxt    = FETCH;
        end else if (count_nxt < CW'(FIFO_DEPTH)) begin
          state_nxt = FETCH;
        end
      end
      DRAIN: begin
        // imem_addr must stay on the squashed address until its ack lands.
        if (branch_taken) pend_pc_nxt = tgt;
        if (imem.ack) begin
          fetch_pc_nxt = branch_taken ? tgt : pend_pc;
          state_nxt    = FETCH;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      pend_pc  <= RESET_PC;
    end else begin
      state    <= state_nxt;
      fetch_pc <= fetch_pc_nxt;
      pend_pc  <= pend_pc_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (branch_taken) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo[wr_ptr] <= '{word: imem.rdata, pc4: fetch_pc + 32'd4};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inst      <= '0;
      pc4_out   <= '0;
      valid_out <= 1'b0;
    end else if (branch_taken) begin
      inst      <= '0;
      valid_out <= 1'b0;
    end else if (!stall) begin
      if (count != '0) begin
        inst      <= head.word;
        pc4_out   <= head.pc4;
        valid_out <= 1'b1;
      end else begin
        inst      <= '0;
        valid_out <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_stage1_if.sv
// Directed bench for stage1_if: table of per-edge vectors plus async-reset and RESET_PC wrap checks.
module tb_stage1_if;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic        hold_ack = 1'b0;
  logic [31:0] inst, pc4_out, inst2, pc42;
  logic        valid_out, valid2;

  int errors = 0;
  int checks = 0;

  stage1_if_if bus ();
  stage1_if_if bus2 ();

  // Memory model: mem[a] = a, zero-wait unless hold_ack stretches the ack.
  assign bus.ack    = bus.req && !hold_ack;
  assign bus.rdata  = bus.addr;
  assign bus2.ack   = bus2.req;
  assign bus2.rdata = bus2.addr;

  always #5 clk = ~clk;

  stage1_if dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .imem(bus.master),
    .inst(inst), .pc4_out(pc4_out), .valid_out(valid_out)
  );

  stage1_if #(.RESET_PC(32'hFFFF_FFF8)) dut2 (
    .clk(clk), .rst_n(rst_n), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .imem(bus2.master),
    .inst(inst2), .pc4_out(pc42), .valid_out(valid2)
  );

  typedef struct packed {
    logic        s;
    logic        b;
    logic [31:0] t;
    logic        h;
    logic        req;
    logic [31:0] addr;
    logic        v;
    logic [31:0] inst;
    logic [31:0] pc4;
  } vec_t;

  vec_t tbl[$];
  logic [31:0] exp2_addr [5];
  logic [31:0] exp2_inst [5];
  logic [31:0] exp2_pc4  [5];

  function automatic vec_t mk(logic s, logic b, logic [31:0] t, logic h, logic rq,
                              logic [31:0] a, logic v, logic [31:0] i, logic [31:0] p);
    vec_t r;
    r = '{s: s, b: b, t: t, h: h, req: rq, addr: a, v: v, inst: i, pc4: p};
    return r;
  endfunction

  task automatic check(input string name, input int row, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
    end
  endtask

  task automatic check_all(input int row, input logic rq, input logic [31:0] a,
                           input logic v, input logic [31:0] i, input logic [31:0] p);
    check("imem_req",  row, 32'(bus.req),   32'(rq));
    check("imem_addr", row, bus.addr,       a);
    check("valid_out", row, 32'(valid_out), 32'(v));
    check("inst",      row, inst,           i);
    check("pc4_out",   row, pc4_out,        p);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //          s  b  tgt           h  req addr          v  inst          pc4
    tbl.push_back(mk(0, 0, 32'h0,   0, 1, 32'h000,   0, 32'h000, 32'h000)); // E1
    tbl.push_back(mk(0, 0, 32'h0,   0, 1, 32'h004,   0, 32'h000, 32'h000));
    tbl.push_back(mk(0, 0, 32'h0,   0, 1, 32'h008,   1, 32'h000, 32'h004));
    tbl.push_back(mk(0, 0, 32'h0,   0, 1, 32'h00C,   1, 32'h004, 32'h008));
    tbl.push_back(mk(0, 0, 32'h0,   0, 1, 32'h010,   1, 32'h008, 32'h00C)); // E5
    tbl.push_back(mk(1, 0, 32'h0,   0, 0, 32'h014,   1, 32'h008, 32'h00C)); // stall: fill
    tbl.push_back(mk(1, 0, 32'h0,   0, 0, 32'h014,   1, 32'h008, 32'h00C));
    tbl.push_back(mk(1, 0, 32'h0,   0, 0, 32'h014,   1, 32'h008, 32'h00C));
    tbl.push_back(mk(0, 0, 32'h0,   0, 1, 32'h014,   1, 32'h00C, 32'h010)); // drain, no gap
    tbl.push_back(mk(0, 0, 32'h0,   0, 1, 32'h018,   1, 32'h010, 32'h014));
    tbl.push_back(mk(0, 0, 32'h0,   0, 1, 32'h01C,   1, 32'h014, 32'h018));
    tbl.push_back(mk(0, 1, 32'h40,  0, 1, 32'h040,   0, 32'h000, 32'h018)); // branch with ack
    tbl.push_back(mk(0, 0, 32'h0,   0, 1, 32'h044,   0, 32'h000, 32'h018));
    tbl.push_back(mk(0, 0, 32'h0,   0, 1, 32'h048,   1, 32'h040, 32'h044));
    tbl.push_back(mk(0, 0, 32'h0,   0, 1, 32'h04C,   1, 32'h044, 32'h048)); // E15
    tbl.push_back(mk(0, 1, 32'h100, 1, 1, 32'h04C,   0, 32'h000, 32'h048)); // branch, no ack
    tbl.push_back(mk(0, 0, 32'h0,   1, 1, 32'h04C,   0, 32'h000, 32'h048));
    tbl.push_back(mk(0, 0, 32'h0,   1, 1, 32'h04C,   0, 32'h000, 32'h048));
    tbl.push_back(mk(0, 0, 32'h0,   0, 1, 32'h100,   0, 32'h000, 32'h048)); // stale ack dropped
    tbl.push_back(mk(0, 0, 32'h0,   0, 1, 32'h104,   0, 32'h000, 32'h048));
    tbl.push_back(mk(0, 0, 32'h0,   0, 1, 32'h108,   1, 32'h100, 32'h104));
    tbl.push_back(mk(0, 1, 32'h300, 1, 1, 32'h108,   0, 32'h000, 32'h104)); // DRAIN
    tbl.push_back(mk(0, 1, 32'h203, 1, 1, 32'h108,   0, 32'h000, 32'h104)); // retarget, lsb ignored
    tbl.push_back(mk(0, 0, 32'h0,   0, 1, 32'h200,   0, 32'h000, 32'h104));
    tbl.push_back(mk(0, 0, 32'h0,   0, 1, 32'h204,   0, 32'h000, 32'h104));
    tbl.push_back(mk(0, 0, 32'h0,   0, 1, 32'h208,   1, 32'h200, 32'h204));
    tbl.push_back(mk(1, 0, 32'h0,   0, 0, 32'h20C,   1, 32'h200, 32'h204)); // FULL
    tbl.push_back(mk(1, 1, 32'h80,  0, 1, 32'h080,   0, 32'h000, 32'h204)); // branch from FULL under stall
    tbl.push_back(mk(0, 0, 32'h0,   0, 1, 32'h084,   0, 32'h000, 32'h204));
    tbl.push_back(mk(0, 0, 32'h0,   0, 1, 32'h088,   1, 32'h080, 32'h084));

    exp2_addr = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004, 32'h0000_0008};
    exp2_inst = '{32'h0, 32'h0, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
    exp2_pc4  = '{32'h0, 32'h0, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_all(-1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    check("rst_addr2", -1, bus2.addr, 32'hFFFF_FFF8);
    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < tbl.size(); k++) begin
      stall         = tbl[k].s;
      branch_taken  = tbl[k].b;
      branch_target = tbl[k].t;
      hold_ack      = tbl[k].h;
      @(posedge clk);
      #1;
      check_all(k, tbl[k].req, tbl[k].addr, tbl[k].v, tbl[k].inst, tbl[k].pc4);
      if (k < 5) begin
        check("wrap_addr", k, bus2.addr, exp2_addr[k]);
        check("wrap_inst", k, inst2,     exp2_inst[k]);
        check("wrap_pc4",  k, pc42,      exp2_pc4[k]);
      end
      @(negedge clk);
    end

    // Async reset between edges, then restart from RESET_PC
    stall = 1'b0; branch_taken = 1'b0; branch_target = '0; hold_ack = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_all(100, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_all(101, 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
    @(posedge clk); #1;
    check_all(102, 1'b1, 32'h4, 1'b0, 32'h0, 32'h0);
    @(posedge clk); #1;
    check_all(103, 1'b1, 32'h8, 1'b1, 32'h0, 32'h4);
    @(posedge clk); #1;
    check_all(104, 1'b1, 32'hC, 1'b1, 32'h4, 32'h8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
